// File: rtl/pill_batch_counter.sv
// Pill/bottle batch counting controller: auto-rate or debounced manual counting,
// per-bottle completion pulse and a blinking batch-done indicator.
module pill_batch_counter #(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned AUTO_DIV   = 50_000_000,
    parameter int unsigned DEB_CYCLES = 25_000,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             key_n,
    input  logic [CNT_W-1:0] set_val,
    output logic [CNT_W-1:0] bottle_tgt,
    output logic [CNT_W-1:0] pill_tgt,
    output logic [CNT_W-1:0] bottle_cnt,
    output logic [CNT_W-1:0] pill_cnt,
    output logic             bottle_done,
    output logic             batch_done,
    output logic             led_n
);

    localparam int unsigned PRE_W   = $clog2(AUTO_DIV);
    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(AUTO_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEB_CYCLES);
    localparam logic [DEB_W-1:0]   DEB_ARM   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

    localparam logic [2:0] MODE_SET_BOTTLE = 3'd1;
    localparam logic [2:0] MODE_SET_PILL   = 3'd2;
    localparam logic [2:0] MODE_AUTO       = 3'd3;
    localparam logic [2:0] MODE_MANUAL     = 3'd4;

    logic [PRE_W-1:0]   pre_q;
    logic [1:0]         sync_q;
    logic [DEB_W-1:0]   deb_q;
    logic               key_pulse_q;
    logic [BLINK_W-1:0] blink_q;
    logic               led_q;

    logic [CNT_W-1:0] btgt_q, btgt_d, ptgt_q, ptgt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d, pcnt_q, pcnt_d;
    logic             bdone_q, bdone_d, batch_q, batch_d;

    logic             key_s;
    logic             tick;
    logic             count_event;
    logic [CNT_W:0]   pill_inc, bottle_inc;

    assign tick        = (mode == MODE_AUTO) && (pre_q == PRE_MAX);
    assign key_s       = sync_q[1];
    assign count_event = tick || ((mode == MODE_MANUAL) && key_pulse_q);
    assign pill_inc    = {1'b0, pcnt_q} + (CNT_W+1)'(1);
    assign bottle_inc  = {1'b0, bcnt_q} + (CNT_W+1)'(1);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else if (mode != MODE_AUTO || tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Synchroniser idles high so reset does not look like a held key.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            deb_q       <= '0;
            key_pulse_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_n};
            key_pulse_q <= !key_s && (deb_q == DEB_ARM);
            if (key_s) begin
                deb_q <= '0;
            end else if (deb_q != DEB_MAX) begin
                deb_q <= deb_q + DEB_W'(1);
            end
        end
    end

    always_comb begin
        btgt_d  = btgt_q;
        ptgt_d  = ptgt_q;
        bcnt_d  = bcnt_q;
        pcnt_d  = pcnt_q;
        batch_d = batch_q;
        bdone_d = 1'b0;
        case (mode)
            MODE_SET_BOTTLE, MODE_SET_PILL: begin
                if (mode == MODE_SET_BOTTLE) btgt_d = set_val;
                else                         ptgt_d = set_val;
                bcnt_d  = '0;
                pcnt_d  = '0;
                batch_d = 1'b0;
            end
            default: begin
                if (count_event && !batch_q && ptgt_q != '0 && btgt_q != '0) begin
                    if (pill_inc < {1'b0, ptgt_q}) begin
                        pcnt_d = pill_inc[CNT_W-1:0];
                    end else begin
                        pcnt_d  = '0;
                        bdone_d = 1'b1;
                        if (bottle_inc == {1'b0, btgt_q}) begin
                            bcnt_d  = btgt_q;
                            batch_d = 1'b1;
                        end else begin
                            bcnt_d = bottle_inc[CNT_W-1:0];
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            btgt_q  <= '0;
            ptgt_q  <= '0;
            bcnt_q  <= '0;
            pcnt_q  <= '0;
            bdone_q <= 1'b0;
            batch_q <= 1'b0;
        end else begin
            btgt_q  <= btgt_d;
            ptgt_q  <= ptgt_d;
            bcnt_q  <= bcnt_d;
            pcnt_q  <= pcnt_d;
            bdone_q <= bdone_d;
            batch_q <= batch_d;
        end
    end

    // Blink starts the cycle after batch_done rises; clearing snaps the LED off at once.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            blink_q <= '0;
            led_q   <= 1'b1;
        end else if (!batch_d) begin
            blink_q <= '0;
            led_q   <= 1'b1;
        end else if (batch_q) begin
            if (blink_q == BLINK_MAX) begin
                blink_q <= '0;
                led_q   <= !led_q;
            end else begin
                blink_q <= blink_q + BLINK_W'(1);
            end
        end
    end

    assign bottle_tgt  = btgt_q;
    assign pill_tgt    = ptgt_q;
    assign bottle_cnt  = bcnt_q;
    assign pill_cnt    = pcnt_q;
    assign bottle_done = bdone_q;
    assign batch_done  = batch_q;
    assign led_n       = led_q;

endmodule

// File: tb/tb_pill_batch_counter.sv
// Directed bench for pill_batch_counter: vector table for the auto batch and blink,
// hand sequences for debounce, zero target, mode abort and asynchronous reset.
module tb_pill_batch_counter;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [2:0] mode;
    logic       key_n;
    logic [3:0] set_val;
    logic [3:0] bottle_tgt, pill_tgt, bottle_cnt, pill_cnt;
    logic       bottle_done, batch_done, led_n;
    logic [18:0] outv;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0]  mode;
        logic [3:0]  set_val;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    pill_batch_counter #(
        .CNT_W(4), .AUTO_DIV(4), .DEB_CYCLES(3), .BLINK_DIV(2)
    ) dut (
        .clk_in(clk_in), .rst(rst), .mode(mode), .key_n(key_n), .set_val(set_val),
        .bottle_tgt(bottle_tgt), .pill_tgt(pill_tgt), .bottle_cnt(bottle_cnt),
        .pill_cnt(pill_cnt), .bottle_done(bottle_done), .batch_done(batch_done),
        .led_n(led_n)
    );

    always #5 clk_in = ~clk_in;

    assign outv = {pill_tgt, bottle_tgt, pill_cnt, bottle_cnt, bottle_done, batch_done, led_n};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Expected record after each edge: {pill_tgt, bottle_tgt, pill_cnt, bottle_cnt, bdone, batch, led_n}
    function automatic void addn(input int n, input logic [2:0] m, input logic [3:0] sv,
                                 input logic [3:0] pt, input logic [3:0] bt,
                                 input logic [3:0] pc, input logic [3:0] bc,
                                 input logic bd, input logic ba, input logic led);
        vec_t v;
        v.mode    = m;
        v.set_val = sv;
        v.exp     = {pt, bt, pc, bc, bd, ba, led};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b0; mode = 3'd0; key_n = 1'b1; set_val = 4'd0;

        // Auto batch pill_tgt=3, bottle_tgt=2; one update per 4 edges in mode 3.
        addn(1, 3'd1, 4'd2, 4'd0, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        addn(1, 3'd2, 4'd3, 4'd3, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        addn(3, 3'd3, 4'd0, 4'd3, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); // edges 1-3
        addn(4, 3'd3, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1); // 4-7
        addn(4, 3'd3, 4'd0, 4'd3, 4'd2, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1); // 8-11
        addn(1, 3'd3, 4'd0, 4'd3, 4'd2, 4'd0, 4'd1, 1'b1, 1'b0, 1'b1); // 12
        addn(3, 3'd3, 4'd0, 4'd3, 4'd2, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1); // 13-15
        addn(4, 3'd3, 4'd0, 4'd3, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0, 1'b1); // 16-19
        addn(4, 3'd3, 4'd0, 4'd3, 4'd2, 4'd2, 4'd1, 1'b0, 1'b0, 1'b1); // 20-23
        addn(1, 3'd3, 4'd0, 4'd3, 4'd2, 4'd0, 4'd2, 1'b1, 1'b1, 1'b1); // 24
        addn(1, 3'd3, 4'd0, 4'd3, 4'd2, 4'd0, 4'd2, 1'b0, 1'b1, 1'b1); // 25
        addn(2, 3'd3, 4'd0, 4'd3, 4'd2, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0); // 26-27
        addn(2, 3'd3, 4'd0, 4'd3, 4'd2, 4'd0, 4'd2, 1'b0, 1'b1, 1'b1); // 28-29
        addn(2, 3'd3, 4'd0, 4'd3, 4'd2, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0); // 30-31
        addn(1, 3'd1, 4'd2, 4'd3, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); // clear

        // Asynchronous reset, checked before any clock edge.
        #3 rst = 1'b1;
        #1 check("reset_async", 32'(outv), 32'h1);
        step();
        step();
        rst = 1'b0;
        check("reset_hold", 32'(outv), 32'h1);

        foreach (vecs[i]) begin
            mode    = vecs[i].mode;
            set_val = vecs[i].set_val;
            step();
            check($sformatf("vec%0d", i), 32'(outv), 32'(vecs[i].exp));
        end

        // Zero pill target: nothing may count.
        mode = 3'd2; set_val = 4'd0; step();
        mode = 3'd3;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("zero_tgt%0d", i), {pill_cnt, bottle_cnt, bottle_done}, 32'h0);
        end

        // Debounce: pill_tgt=5, bottle_tgt=1, manual mode.
        mode = 3'd1; set_val = 4'd1; step();
        mode = 3'd2; set_val = 4'd5; step();
        mode = 3'd4;
        repeat (3) step();
        key_n = 1'b0; step(); step(); key_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("short_press%0d", i), {pill_cnt, bottle_done}, 32'h0);
        end
        key_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("long_press_e%0d", i), {pill_cnt, bottle_done},
                  (i >= 5) ? 32'h2 : 32'h0);
        end
        key_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("release%0d", i), {pill_cnt, bottle_done}, 32'h2);
        end

        // Mode abort: leave mode 3 at prescaler=2, return, next update 4 edges later.
        mode = 3'd1; set_val = 4'd3; step();
        mode = 3'd2; set_val = 4'd5; step();
        mode = 3'd3; step(); step();
        check("abort_pre", 32'(pill_cnt), 32'h0);
        mode = 3'd0; step();
        mode = 3'd3;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("abort_resume%0d", i), 32'(pill_cnt), (i == 4) ? 32'h1 : 32'h0);
        end

        // Reset mid-operation takes effect without a clock edge.
        #2 rst = 1'b1;
        #1 check("reset_midop", 32'(outv), 32'h1);
        step();
        rst = 1'b0;
        step();
        check("after_reset", 32'(outv), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
